// File: rtl/pixel_stream_pkg.sv
// Shared timing defaults, FSM state type and pattern helper
// for the pixel stream source and its detector bench.
package pixel_stream_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_TOTAL  = 900;
    localparam int DEF_V_ACTIVE = 600;
    localparam int DEF_V_TOTAL  = 700;

    localparam int CNT_W  = 10;
    localparam int ADDR_W = 19;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    function automatic logic [7:0] pattern_pix(
        input logic [CNT_W-1:0] row,
        input logic [CNT_W-1:0] col
    );
        return row[7:0] ^ col[7:0];
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Horizontal/vertical raster position counters.
// h runs 0..H_TOTAL-1, v advances on each h wrap.
module raster_counter
    import pixel_stream_pkg::*;
#(
    parameter int H_TOTAL = DEF_H_TOTAL,
    parameter int V_TOTAL = DEF_V_TOTAL
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    output logic [CNT_W-1:0] h,
    output logic [CNT_W-1:0] v,
    output logic             h_wrap,
    output logic             v_wrap
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    assign h_wrap = (h == H_LAST);
    assign v_wrap = (v == V_LAST);

    // Advance the raster; both counters return to 0 at frame end.
    always_ff @(posedge clock) begin
        if (reset) begin
            h <= '0;
            v <= '0;
        end else if (enable) begin
            if (h_wrap) begin
                h <= '0;
                if (v_wrap) v <= '0;
                else        v <= v + 1'b1;
            end else begin
                h <= h + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pixel_stream_source.sv
// Raster-scanned pixel source reading a linear frame buffer.
// Optional TEST_PATTERN_EN adds a pattern_en input (col^row pixels).
module pixel_stream_source
    import pixel_stream_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_TOTAL  = DEF_H_TOTAL,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_TOTAL  = DEF_V_TOTAL
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              continuous,
`ifdef TEST_PATTERN_EN
    input  logic              pattern_en,
`endif
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] dout,
    output logic              validout,
    output logic [CNT_W-1:0]  rowcount,
    output logic [CNT_W-1:0]  colcount,
    output logic              frame_start,
    output logic              frame_done,
    output logic              busy
);

    localparam logic [CNT_W-1:0] H_ACT = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT = CNT_W'(V_ACTIVE);

    state_t state;
    state_t state_nxt;

    logic [CNT_W-1:0]  h;
    logic [CNT_W-1:0]  v;
    logic              h_wrap;
    logic              v_wrap;
    logic              scan;
    logic              active;
    logic              frame_end;
    logic              stage_q;
    logic [DATA_W-1:0] dout_q;
    logic [DATA_W-1:0] src;

    assign scan      = (state == ST_SCAN);
    assign active    = scan && (h < H_ACT) && (v < V_ACT);
    assign frame_end = scan && h_wrap && v_wrap;

    raster_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_raster (
        .clock  (clock),
        .reset  (reset),
        .enable (scan),
        .h      (h),
        .v      (v),
        .h_wrap (h_wrap),
        .v_wrap (v_wrap)
    );

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Start opens a frame; frame end closes it unless continuous.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (start) state_nxt = ST_SCAN;
            ST_SCAN: if (frame_end && !continuous) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Linear read address: steps per active pixel, clears at frame wrap.
    always_ff @(posedge clock) begin
        if (reset || !scan || frame_end) mem_addr <= '0;
        else if (active)                 mem_addr <= mem_addr + 1'b1;
    end

`ifdef TEST_PATTERN_EN
    assign mem_rd = active && !pattern_en;
    assign src    = pattern_en
                  ? DATA_W'(pattern_pix(rowcount, colcount))
                  : mem_data;
`else
    assign mem_rd = active;
    assign src    = mem_data;
`endif

    // Read data lands with the registered stage; blanking holds it.
    assign dout = validout ? src : dout_q;
    assign busy = scan || stage_q;

    // Output stage: position and status one cycle behind the counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            validout    <= 1'b0;
            rowcount    <= '0;
            colcount    <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            stage_q     <= 1'b0;
            dout_q      <= '0;
        end else begin
            validout    <= active;
            frame_start <= scan && (h == '0) && (v == '0);
            frame_done  <= frame_end;
            stage_q     <= scan;
            dout_q      <= dout;
            if (scan) begin
                rowcount <= v;
                colcount <= h;
            end
        end
    end

endmodule

// File: tb/tb_pixel_stream_source.sv
// Scoreboard bench for pixel_stream_source on a reduced raster.
// Pattern checks run only when TEST_PATTERN_EN is defined.
module tb_pixel_stream_source;

    localparam int HA    = 300;
    localparam int HT    = 310;
    localparam int VA    = 4;
    localparam int VT    = 5;
    localparam int FRAME = HT * VT;
    localparam int NPIX  = HA * VA;

    typedef struct {
        int r;
        int c;
        int d;
    } pix_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic        continuous;
`ifdef TEST_PATTERN_EN
    logic        pattern_en;
`endif
    logic        mem_rd;
    logic [18:0] mem_addr;
    logic [7:0]  mem_data;
    logic [7:0]  dout;
    logic        validout;
    logic [9:0]  rowcount;
    logic [9:0]  colcount;
    logic        frame_start;
    logic        frame_done;
    logic        busy;

    pix_t q[$];
    int   n_checks;
    int   n_err;
    int   cyc;
    int   fs_cnt;
    int   v_cnt;
    int   rd_cnt;

    pixel_stream_source #(
        .DATA_W   (8),
        .H_ACTIVE (HA),
        .H_TOTAL  (HT),
        .V_ACTIVE (VA),
        .V_TOTAL  (VT)
    ) dut (
        .clock       (clk),
        .reset       (reset),
        .start       (start),
        .continuous  (continuous),
`ifdef TEST_PATTERN_EN
        .pattern_en  (pattern_en),
`endif
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .dout        (dout),
        .validout    (validout),
        .rowcount    (rowcount),
        .colcount    (colcount),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Frame buffer model: content is the low address byte.
    always @(posedge clk) begin
        if (mem_rd) mem_data <= mem_addr[7:0];
    end

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    task automatic push_frame(input bit pat);
        pix_t p;
        for (int r = 0; r < VA; r++) begin
            for (int c = 0; c < HA; c++) begin
                p.r = r;
                p.c = c;
                if (pat) p.d = (r ^ c) & 8'hff;
                else     p.d = (r * HA + c) % 256;
                q.push_back(p);
            end
        end
    endtask

    task automatic start_pulse();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(posedge clk);
            #1;
            if (frame_done) break;
        end
        check(name, 32'(frame_done), 1);
    endtask

    task automatic wait_pos(input string name,
                            input int r, input int c);
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(posedge clk);
            #1;
            if (validout && rowcount == 10'(r)
                && colcount == 10'(c)) break;
        end
        check(name, 32'(validout && rowcount == 10'(r)
                        && colcount == 10'(c)), 1);
    endtask

    // Monitor: pop and compare every presented pixel.
    always @(negedge clk) begin
        pix_t p;
        if (validout) begin
            v_cnt++;
            if (q.size() == 0) begin
                check("pix_unexpected", 32'(validout), 0);
            end else begin
                p = q.pop_front();
                check("pix_row", 32'(rowcount), p.r);
                check("pix_col", 32'(colcount), p.c);
                check("pix_data", 32'(dout), p.d);
            end
        end
        if (frame_start) fs_cnt++;
        if (mem_rd) rd_cnt++;
    end

    initial begin
        int fs_t;
        int fd_t;
        int rd0;
        n_checks   = 0;
        n_err      = 0;
        cyc        = 0;
        fs_cnt     = 0;
        v_cnt      = 0;
        rd_cnt     = 0;
        mem_data   = '0;
        reset      = 1'b1;
        start      = 1'b0;
        continuous = 1'b0;
`ifdef TEST_PATTERN_EN
        pattern_en = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        check("rst_valid", 32'(validout), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rd", 32'(mem_rd), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_fs", 32'(frame_start), 0);
        check("rst_fd", 32'(frame_done), 0);
        check("rst_row", 32'(rowcount), 0);
        check("rst_col", 32'(colcount), 0);
        check("rst_dout", 32'(dout), 0);

        // Single frame with a stray start mid-frame.
        push_frame(1'b0);
        start_pulse();
        check("first_rd", 32'(mem_rd), 1);
        check("first_addr", 32'(mem_addr), 0);
        @(posedge clk);
        #1;
        fs_t = cyc;
        check("first_valid", 32'(validout), 1);
        check("first_fs", 32'(frame_start), 1);
        check("first_row", 32'(rowcount), 0);
        check("first_col", 32'(colcount), 0);
        check("first_dout", 32'(dout), 0);
        wait_pos("wait_r1c0", 1, 0);
        check("r1c0_dout", 32'(dout), HA % 256);
        start_pulse();
        wait_done("wait_fd1");
        fd_t = cyc;
        check("frame_len", fd_t - fs_t, FRAME - 1);
        check("fd_busy", 32'(busy), 1);
        check("fd_row", 32'(rowcount), VT - 1);
        check("fd_col", 32'(colcount), HT - 1);
        check("fd_hold", 32'(dout), (NPIX - 1) % 256);
        @(posedge clk);
        #1;
        check("post_busy", 32'(busy), 0);
        check("post_valid", 32'(validout), 0);
        repeat (20) @(posedge clk);
        #1;
        check("idle_busy", 32'(busy), 0);
        check("fs_cnt1", fs_cnt, 1);
        check("vcnt1", v_cnt, NPIX);

        // Two back-to-back frames, continuous dropped in the second.
        continuous = 1'b1;
        push_frame(1'b0);
        push_frame(1'b0);
        start_pulse();
        @(posedge clk);
        #1;
        check("c_fs1", 32'(frame_start), 1);
        wait_done("wait_cfd1");
        fd_t = cyc;
        check("c_addr0", 32'(mem_addr), 0);
        check("c_rd", 32'(mem_rd), 1);
        @(posedge clk);
        #1;
        check("c_fs2", 32'(frame_start), 1);
        check("c_gap", cyc - fd_t, 1);
        continuous = 1'b0;
        wait_done("wait_cfd2");
        repeat (10) @(posedge clk);
        #1;
        check("c_idle", 32'(busy), 0);
        check("fs_cnt3", fs_cnt, 3);
        check("vcnt3", v_cnt, 3 * NPIX);

        // Reset in the middle of a frame.
        push_frame(1'b0);
        start_pulse();
        wait_pos("wait_r2c150", 2, 150);
        reset = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        check("mr_valid", 32'(validout), 0);
        check("mr_busy", 32'(busy), 0);
        check("mr_rd", 32'(mem_rd), 0);
        check("mr_addr", 32'(mem_addr), 0);
        check("mr_dout", 32'(dout), 0);
        check("mr_row", 32'(rowcount), 0);
        check("mr_col", 32'(colcount), 0);
        check("mr_fs", 32'(frame_start), 0);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mr_idle", 32'(busy), 0);
        push_frame(1'b0);
        start_pulse();
        @(posedge clk);
        #1;
        check("rs_fs", 32'(frame_start), 1);
        check("rs_row", 32'(rowcount), 0);
        check("rs_col", 32'(colcount), 0);
        check("rs_valid", 32'(validout), 1);
        wait_done("wait_rsfd");
        repeat (5) @(posedge clk);
        #1;
        check("fs_cnt5", fs_cnt, 5);

`ifdef TEST_PATTERN_EN
        // Internal pattern: no reads, dout = row ^ col.
        pattern_en = 1'b1;
        rd0 = rd_cnt;
        push_frame(1'b1);
        start_pulse();
        wait_pos("wait_r3c5", 3, 5);
        check("pat_r3c5", 32'(dout), 6);
        wait_done("wait_patfd");
        check("pat_no_rd", rd_cnt - rd0, 0);
        repeat (5) @(posedge clk);
        #1;
        pattern_en = 1'b0;
`else
        rd0 = rd_cnt;
`endif

        check("queue_drain", q.size(), 0);
        check("rd_total", rd_cnt, rd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
